// File: rtl/egg_timer_ctrl.sv
// rtl/egg_timer_ctrl.sv - egg timer countdown controller: seconds prescaler, MM:SS BCD countdown, IDLE/RUN/PAUSE/ALARM sequencing
module egg_timer_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic       tick_en
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ACNT_LAST = AW'(ALARM_SECS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_ALARM = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    mt_q, mo_q, st_q, so_q;
    logic [3:0]    mt_d, mo_d, st_d, so_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          tick_en_q, tick_d;
    logic          running_q, alarm_q;
    logic          tick;
    logic [15:0]   time_q;
    logic          time_zero;
    logic          time_last;

    // Minutes +1 with 99 -> 00 wrap.
    function automatic logic [7:0] min_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [3:0] t;
        logic [3:0] o;
        t = tens;
        o = ones + 4'd1;
        if (ones == 4'd9) begin
            o = 4'd0;
            t = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end
        return {t, o};
    endfunction

    // Seconds +1 with 59 -> 00 wrap; never carries into minutes.
    function automatic logic [7:0] sec_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [3:0] t;
        logic [3:0] o;
        t = tens;
        o = ones + 4'd1;
        if (ones == 4'd9) begin
            o = 4'd0;
            t = (tens == 4'd5) ? 4'd0 : tens + 4'd1;
        end
        return {t, o};
    endfunction

    // MM:SS decrement; only called with a non-zero time so minutes borrow is safe.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        {a, b, c, d} = t;
        if (d != 4'd0) begin
            d = d - 4'd1;
        end else begin
            d = 4'd9;
            if (c != 4'd0) begin
                c = c - 4'd1;
            end else begin
                c = 4'd5;
                if (b != 4'd0) begin
                    b = b - 4'd1;
                end else begin
                    b = 4'd9;
                    a = a - 4'd1;
                end
            end
        end
        return {a, b, c, d};
    endfunction

    assign time_q    = {mt_q, mo_q, st_q, so_q};
    assign time_zero = (time_q == 16'h0000);
    assign time_last = (time_q <= 16'h0001);
    assign tick      = ((state_q == ST_RUN) || (state_q == ST_ALARM)) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        cnt_d   = cnt_q;
        acnt_d  = acnt_q;
        tick_d  = 1'b0;
        if (btn_clear) begin
            state_d = ST_IDLE;
            {mt_d, mo_d, st_d, so_d} = 16'h0000;
            cnt_d   = '0;
            acnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d  = '0;
                    acnt_d = '0;
                    if (btn_start) begin
                        if (!time_zero) state_d = ST_RUN;
                    end else begin
                        if (btn_min) {mt_d, mo_d} = min_inc(mt_q, mo_q);
                        if (btn_sec) {st_d, so_d} = sec_inc(st_q, so_q);
                    end
                end
                ST_RUN: begin
                    cnt_d = tick ? '0 : cnt_q + CW'(1);
                    if (tick) begin
                        tick_d = 1'b1;
                        // Reaching zero wins over a simultaneous pause request.
                        if (time_last) begin
                            {mt_d, mo_d, st_d, so_d} = 16'h0000;
                            state_d = ST_ALARM;
                            acnt_d  = '0;
                        end else begin
                            {mt_d, mo_d, st_d, so_d} = bcd_dec(time_q);
                            if (btn_start) begin
                                state_d = ST_PAUSE;
                                cnt_d   = '0;
                            end
                        end
                    end else if (btn_start) begin
                        state_d = ST_PAUSE;
                        cnt_d   = '0;
                    end
                end
                ST_PAUSE: begin
                    cnt_d = '0;
                    if (btn_start) state_d = ST_RUN;
                end
                ST_ALARM: begin
                    {mt_d, mo_d, st_d, so_d} = 16'h0000;
                    if (tick) begin
                        tick_d = 1'b1;
                        cnt_d  = '0;
                        if (acnt_q == ACNT_LAST) begin
                            state_d = ST_IDLE;
                            acnt_d  = '0;
                        end else begin
                            acnt_d = acnt_q + AW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (btn_start) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        acnt_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    {mt_d, mo_d, st_d, so_d} = 16'h0000;
                    cnt_d   = '0;
                    acnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mt_q      <= 4'd0;
            mo_q      <= 4'd0;
            st_q      <= 4'd0;
            so_q      <= 4'd0;
            cnt_q     <= '0;
            acnt_q    <= '0;
            tick_en_q <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mt_q      <= mt_d;
            mo_q      <= mo_d;
            st_q      <= st_d;
            so_q      <= so_d;
            cnt_q     <= cnt_d;
            acnt_q    <= acnt_d;
            tick_en_q <= tick_d;
            running_q <= (state_d == ST_RUN);
            alarm_q   <= (state_d == ST_ALARM);
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign running  = running_q;
    assign alarm    = alarm_q;
    assign tick_en  = tick_en_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb/tb_egg_timer_ctrl.sv - directed self-checking bench for egg_timer_ctrl
module tb_egg_timer_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_sec = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, alarm, tick_en;
    logic [15:0] digits;
    int         checks = 0;
    int         errors = 0;
    int         tick_seen;

    egg_timer_ctrl #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_min   (btn_min),
        .btn_sec   (btn_sec),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .alarm     (alarm),
        .tick_en   (tick_en)
    );

    always #5 clk_in = ~clk_in;

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pulse(input logic s, input logic c, input logic m, input logic sc);
        @(negedge clk_in);
        btn_start = s;
        btn_clear = c;
        btn_min   = m;
        btn_sec   = sc;
        @(posedge clk_in);
        #1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_min   = 1'b0;
        btn_sec   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic set_secs(input int n);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] exp_t2 [0:2];
        exp_t2[0] = 16'h0101;
        exp_t2[1] = 16'h0100;
        exp_t2[2] = 16'h0059;

        // 1: reset and setting the time
        #3;
        check("rst_digits", digits, 16'h0000);
        check("rst_running", running, 0);
        check("rst_alarm", alarm, 0);
        check("rst_tick", tick_en, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("set_0102", digits, 16'h0102);
        check("set_running", running, 0);

        // 2: countdown with borrow across the minute
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_running", running, 1);
        check("start_digits", digits, 16'h0102);
        for (int i = 1; i <= 12; i++) begin
            cycles(1);
            check($sformatf("t2_tick_c%0d", i), tick_en, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) check($sformatf("t2_dig_%0d", i / 4), digits, exp_t2[i / 4 - 1]);
        end

        // 3: countdown into alarm, alarm auto-expiry after three ticks
        set_secs(2);
        check("t3_set", digits, 16'h0002);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(4);
        check("t3_0001", digits, 16'h0001);
        cycles(4);
        check("t3_zero", digits, 16'h0000);
        check("t3_alarm", alarm, 1);
        check("t3_run_off", running, 0);
        check("t3_tick", tick_en, 1);
        cycles(11);
        check("t3_alarm_hold", alarm, 1);
        cycles(1);
        check("t3_alarm_done", alarm, 0);
        check("t3_exit_tick", tick_en, 1);
        check("t3_idle_run", running, 0);
        check("t3_idle_dig", digits, 16'h0000);

        // 3b: alarm acknowledged by btn_start
        set_secs(1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(4);
        check("ack_alarm_on", alarm, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("ack_alarm_off", alarm, 0);
        check("ack_running", running, 0);
        cycles(4);
        check("ack_no_tick", tick_en, 0);

        // 4: pause freezes digits and drops the partial second
        set_secs(30);
        check("t4_set", digits, 16'h0030);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_paused", running, 0);
        tick_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (tick_en) tick_seen++;
        end
        check("t4_pause_ticks", tick_seen, 0);
        check("t4_pause_dig", digits, 16'h0030);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_resumed", running, 1);
        cycles(3);
        check("t4_partial_lost", digits, 16'h0030);
        check("t4_partial_tick", tick_en, 0);
        // tick and pause land on the same edge
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_tick_pause_dig", digits, 16'h0029);
        check("t4_tick_pause_run", running, 0);
        check("t4_tick_pause_tick", tick_en, 1);
        cycles(1);
        check("t4_tick_single", tick_en, 0);

        // 5: IDLE wraps, both buttons, start ignored at 00:00, start beats min
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_sec59", digits, 16'h0059);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_sec_wrap", digits, 16'h0000);
        for (int i = 0; i < 99; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_min99", digits, 16'h9900);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_min_wrap", digits, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_start_zero", running, 0);
        cycles(5);
        check("t5_zero_no_tick", tick_en, 0);
        check("t5_zero_dig", digits, 16'h0000);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_both", digits, 16'h0101);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_start_prio_run", running, 1);
        check("t5_start_prio_dig", digits, 16'h0101);

        // 6: clear beats start in RUN; async reset mid-countdown
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_clear_run", running, 0);
        check("t6_clear_dig", digits, 16'h0000);
        check("t6_clear_alarm", alarm, 0);
        set_secs(5);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(5);
        check("t6_pre_rst", digits, 16'h0004);
        @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        check("t6_rst_dig", digits, 16'h0000);
        check("t6_rst_run", running, 0);
        check("t6_rst_alarm", alarm, 0);
        check("t6_rst_tick", tick_en, 0);
        cycles(3);
        @(negedge clk_in);
        rst_n = 1'b1;
        cycles(6);
        check("t6_post_run", running, 0);
        check("t6_post_alarm", alarm, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
